// File: rtl/scan_decoder.sv
// Registered SEL_W-to-2**SEL_W line decoder with an optional autonomous scan mode
// that steps the active line with a prescaled up/down counter.
module scan_decoder #(
    parameter int SEL_W      = 3,
    parameter int DIV        = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel_in,
    input  logic                  load,
    input  logic                  dir,
    output logic [2**SEL_W-1:0]   d,
    output logic [SEL_W-1:0]      cur_sel,
    output logic                  wrap
);

    localparam int OUT_N = 2**SEL_W;
    localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0]    DIV_M1   = PW'(DIV - 1);
    localparam logic [OUT_N-1:0] INACTIVE = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [PW-1:0]    pre;
    logic [PW-1:0]    pre_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic             wrap_nxt;

    function automatic logic [OUT_N-1:0] decode(input logic [SEL_W-1:0] s);
        logic [OUT_N-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return (ACTIVE_LOW != 0) ? ~v : v;
    endfunction

    // Direct decode and load both restart the prescaler so a scan always gets a full period.
    always_comb begin
        sel_nxt  = cur_sel;
        pre_nxt  = pre;
        wrap_nxt = 1'b0;
        if (!mode || load) begin
            sel_nxt = sel_in;
            pre_nxt = '0;
        end else if (pre == DIV_M1) begin
            sel_nxt  = dir ? (cur_sel - SEL_W'(1)) : (cur_sel + SEL_W'(1));
            pre_nxt  = '0;
            wrap_nxt = dir ? (cur_sel == '0) : (cur_sel == '1);
        end else begin
            pre_nxt = pre + PW'(1);
        end
    end

    // Disabled: blank the outputs but keep index and prescaler frozen for resumption.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_sel <= '0;
            pre     <= '0;
            wrap    <= 1'b0;
            d       <= INACTIVE;
        end else if (!en) begin
            d    <= INACTIVE;
            wrap <= 1'b0;
        end else begin
            cur_sel <= sel_nxt;
            pre     <= pre_nxt;
            wrap    <= wrap_nxt;
            d       <= decode(sel_nxt);
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder: a DIV=4 active-high instance and a DIV=1
// active-low instance share stimulus and are checked against a behavioural model.
module tb_scan_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode;
    logic       load;
    logic       dir;
    logic [2:0] sel_in;
    logic [7:0] d_a;
    logic [7:0] d_b;
    logic [2:0] cur_a;
    logic [2:0] cur_b;
    logic       wrap_a;
    logic       wrap_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    scan_decoder #(.SEL_W(3), .DIV(4), .ACTIVE_LOW(0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in),
        .load(load), .dir(dir), .d(d_a), .cur_sel(cur_a), .wrap(wrap_a)
    );

    scan_decoder #(.SEL_W(3), .DIV(1), .ACTIVE_LOW(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in),
        .load(load), .dir(dir), .d(d_b), .cur_sel(cur_b), .wrap(wrap_b)
    );

    typedef struct {
        logic       en;
        logic       mode;
        logic       load;
        logic       dir;
        logic [2:0] sel;
        logic [7:0] d;
        logic [2:0] cur;
        logic       wrap;
    } vec_t;

    vec_t vecs[$];

    // Reference model: index, cycles elapsed since last step, last wrap, outputs-active flag.
    int m_idx[2];
    int m_cnt[2];
    bit m_wrap[2];
    bit m_act[2];
    int m_div[2] = '{4, 1};
    bit m_al[2]  = '{1'b0, 1'b1};

    function automatic void modelReset();
        for (int k = 0; k < 2; k++) begin
            m_idx[k]  = 0;
            m_cnt[k]  = 0;
            m_wrap[k] = 1'b0;
            m_act[k]  = 1'b0;
        end
    endfunction

    function automatic void modelEdge();
        for (int k = 0; k < 2; k++) begin
            if (!en) begin
                m_wrap[k] = 1'b0;
                m_act[k]  = 1'b0;
            end else begin
                m_act[k] = 1'b1;
                if (!mode || load) begin
                    m_idx[k]  = int'(sel_in);
                    m_cnt[k]  = 0;
                    m_wrap[k] = 1'b0;
                end else if (m_cnt[k] == m_div[k] - 1) begin
                    m_wrap[k] = dir ? (m_idx[k] == 0) : (m_idx[k] == 7);
                    m_idx[k]  = dir ? (m_idx[k] + 7) % 8 : (m_idx[k] + 1) % 8;
                    m_cnt[k]  = 0;
                end else begin
                    m_cnt[k]  = m_cnt[k] + 1;
                    m_wrap[k] = 1'b0;
                end
            end
        end
    endfunction

    function automatic logic [7:0] modelD(int k);
        logic [7:0] v;
        v = m_act[k] ? 8'(1 << m_idx[k]) : 8'h00;
        return m_al[k] ? ~v : v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic m, input logic l,
                                 input logic dr, input logic [2:0] s);
        en     = e;
        mode   = m;
        load   = l;
        dir    = dr;
        sel_in = s;
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic checkOutput(input string tag);
        cmp({tag, "_a_d"},    32'(d_a),    32'(modelD(0)));
        cmp({tag, "_a_cur"},  32'(cur_a),  32'(m_idx[0]));
        cmp({tag, "_a_wrap"}, 32'(wrap_a), 32'(m_wrap[0]));
        cmp({tag, "_b_d"},    32'(d_b),    32'(modelD(1)));
        cmp({tag, "_b_cur"},  32'(cur_b),  32'(m_idx[1]));
        cmp({tag, "_b_wrap"}, 32'(wrap_b), 32'(m_wrap[1]));
    endtask

    task automatic addVec(input logic e, input logic m, input logic l, input logic dr,
                          input logic [2:0] s, input logic [7:0] ed, input logic [2:0] ec,
                          input logic ew);
        vec_t v;
        v.en = e; v.mode = m; v.load = l; v.dir = dr; v.sel = s;
        v.d = ed; v.cur = ec; v.wrap = ew;
        vecs.push_back(v);
    endtask

    // Mid-cycle reset pulse: outputs must go inactive without any clock edge.
    task automatic pulseReset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        cmp({tag, "_async_d_a"},    32'(d_a),    32'h00);
        cmp({tag, "_async_cur_a"},  32'(cur_a),  32'h0);
        cmp({tag, "_async_wrap_a"}, 32'(wrap_a), 32'h0);
        cmp({tag, "_async_d_b"},    32'(d_b),    32'hFF);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] down_d[3];
        logic [2:0] down_cur[3];
        logic       down_wrap[3];
        logic [7:0] rel_d[4];

        rst = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; dir = 1'b0; sel_in = 3'd0;
        modelReset();
        #12;
        cmp("reset_d_a",    32'(d_a),    32'h00);
        cmp("reset_cur_a",  32'(cur_a),  32'h0);
        cmp("reset_wrap_a", 32'(wrap_a), 32'h0);
        cmp("reset_d_b",    32'(d_b),    32'hFF);
        cmp("reset_cur_b",  32'(cur_b),  32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Expected values for the DIV=4 active-high instance.
        addVec(1, 0, 0, 0, 3'd5, 8'h20, 3'd5, 0);
        for (int i = 0; i < 8; i++) addVec(1, 0, 0, 0, 3'(i), 8'(1 << i), 3'(i), 0);
        addVec(1, 0, 0, 0, 3'd6, 8'h40, 3'd6, 0);
        repeat (3) addVec(1, 1, 0, 0, 3'd0, 8'h40, 3'd6, 0);
        repeat (4) addVec(1, 1, 0, 0, 3'd0, 8'h80, 3'd7, 0);
        addVec(1, 1, 0, 0, 3'd0, 8'h01, 3'd0, 1);
        repeat (3) addVec(1, 1, 0, 0, 3'd0, 8'h01, 3'd0, 0);
        addVec(1, 1, 1, 0, 3'd3, 8'h08, 3'd3, 0);
        repeat (3) addVec(1, 1, 0, 0, 3'd0, 8'h08, 3'd3, 0);
        repeat (2) addVec(1, 1, 0, 0, 3'd0, 8'h10, 3'd4, 0);
        repeat (10) addVec(0, 1, 0, 0, 3'd0, 8'h00, 3'd4, 0);
        repeat (2) addVec(1, 1, 0, 0, 3'd0, 8'h10, 3'd4, 0);
        addVec(1, 1, 0, 0, 3'd0, 8'h20, 3'd5, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].en, vecs[i].mode, vecs[i].load, vecs[i].dir, vecs[i].sel);
            cmp($sformatf("tbl%0d_d", i),    32'(d_a),    32'(vecs[i].d));
            cmp($sformatf("tbl%0d_cur", i),  32'(cur_a),  32'(vecs[i].cur));
            cmp($sformatf("tbl%0d_wrap", i), 32'(wrap_a), 32'(vecs[i].wrap));
            checkOutput($sformatf("tbl%0d", i));
        end

        // DIV=1 active-low scan down from index 1, wrapping through 0 to 7.
        applyStimulus(1, 0, 0, 0, 3'd1);
        cmp("down_start_d_b", 32'(d_b), 32'hFD);
        down_d    = '{8'hFE, 8'h7F, 8'hBF};
        down_cur  = '{3'd0, 3'd7, 3'd6};
        down_wrap = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 0, 1, 3'd0);
            cmp($sformatf("down%0d_d_b", i),    32'(d_b),    32'(down_d[i]));
            cmp($sformatf("down%0d_cur_b", i),  32'(cur_b),  32'(down_cur[i]));
            cmp($sformatf("down%0d_wrap_b", i), 32'(wrap_b), 32'(down_wrap[i]));
            checkOutput($sformatf("down%0d", i));
        end

        // Reset mid-scan at index 4, then a full prescale period from index 0.
        applyStimulus(1, 0, 0, 0, 3'd4);
        applyStimulus(1, 1, 0, 0, 3'd0);
        cmp("prerst_cur_a", 32'(cur_a), 32'h4);
        pulseReset("midscan");
        rel_d = '{8'h01, 8'h01, 8'h01, 8'h02};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 0, 0, 3'd0);
            cmp($sformatf("release%0d_d_a", i), 32'(d_a), 32'(rel_d[i]));
            checkOutput($sformatf("release%0d", i));
        end

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                pulseReset($sformatf("rnd%0d", i));
            end
            applyStimulus(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                          3'($urandom_range(0, 7)));
            checkOutput($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
